// File: rtl/sram_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  typedef logic port_t;

  localparam int unsigned NUM_PORTS     = 2;
  localparam logic        CTRL_INACTIVE = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle: both ports' request payloads plus shared read data and per-port Ack.
interface sram_arbiter_if
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) ();

  logic [NUM_PORTS-1:0]             Req;
  logic [NUM_PORTS-1:0]             Wr;
  logic [NUM_PORTS-1:0][1:0]        BE;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] Addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] WData;
  logic [DATA_W-1:0]                RData;
  logic [NUM_PORTS-1:0]             Ack;

  modport master (
    output Req, Wr, BE, Addr, WData,
    input  RData, Ack
  );

  modport slave (
    input  Req, Wr, BE, Addr, WData,
    output RData, Ack
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant selection (round-robin or fixed priority) with a registered fairness pointer.
module rr_arbiter2
  import sram_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 done,
  input  port_t                done_port,
  output logic                 grant_valid_c,
  output port_t                grant_c
);

  // ptr names the port preferred when both request; reset prefers port 0.
  port_t ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (done) begin
      ptr <= ~done_port;
    end
  end

  always_comb begin
    grant_valid_c = |req;
    grant_c       = 1'b0;
    if (FAIR != 0) begin
      grant_c = (req == 2'b11) ? ptr : port_t'(req[1]);
    end else begin
      grant_c = port_t'(~req[0]);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and timing sequencer for an external asynchronous SRAM.
// Each access is a grant, ACCESS_CYCLES of strobe, then one recovery cycle carrying the Ack.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned FAIR          = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Data_oe,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  if (ACCESS_CYCLES < 1) begin : g_bad_access_cycles
    $error("sram_arbiter: ACCESS_CYCLES must be at least 1");
  end

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 load_c, capture_c, done_c;
  logic                 grant_valid_c;
  port_t                grant_c;

  logic                 lat_wr;
  logic [1:0]           lat_be;
  port_t                lat_port;

  logic                 wr_nx;
  logic [1:0]           be_nx;
  port_t                port_nx;
  logic                 ce_nx, oe_nx, we_nx, ub_nx, lb_nx, doe_nx;
  logic [NUM_PORTS-1:0] ack_nx;

  rr_arbiter2 #(.FAIR(FAIR)) u_arb (
    .clk           (Clk),
    .reset         (Reset),
    .req           (bus.Req),
    .done          (done_c),
    .done_port     (lat_port),
    .grant_valid_c (grant_valid_c),
    .grant_c       (grant_c)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and sequencing strobes.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load_c    = 1'b0;
    capture_c = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid_c) begin
          load_c   = 1'b1;
          state_nx = ACCESS;
          cnt_nx   = CNT_W'(ACCESS_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          capture_c = ~lat_wr;
          state_nx  = RECOVER;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state so every pin is a flop.
  always_comb begin
    wr_nx   = load_c ? bus.Wr[grant_c] : lat_wr;
    be_nx   = load_c ? bus.BE[grant_c] : lat_be;
    port_nx = load_c ? grant_c : lat_port;
    ce_nx   = CTRL_INACTIVE;
    oe_nx   = CTRL_INACTIVE;
    we_nx   = CTRL_INACTIVE;
    ub_nx   = CTRL_INACTIVE;
    lb_nx   = CTRL_INACTIVE;
    doe_nx  = 1'b0;
    ack_nx  = '0;
    case (state_nx)
      ACCESS: begin
        ce_nx  = 1'b0;
        oe_nx  = wr_nx;
        we_nx  = ~wr_nx;
        ub_nx  = ~be_nx[1];
        lb_nx  = ~be_nx[0];
        doe_nx = wr_nx;
      end
      RECOVER: begin
        // WE/OE release while CE, byte lanes and write data hold for one more cycle.
        ce_nx           = 1'b0;
        ub_nx           = ~be_nx[1];
        lb_nx           = ~be_nx[0];
        doe_nx          = wr_nx;
        ack_nx[port_nx] = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latches, captured read data and registered pins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      A            <= '0;
      Data_to_SRAM <= '0;
      lat_wr       <= 1'b0;
      lat_be       <= '0;
      lat_port     <= 1'b0;
      bus.RData    <= '0;
      bus.Ack      <= '0;
      CE           <= CTRL_INACTIVE;
      OE           <= CTRL_INACTIVE;
      WE           <= CTRL_INACTIVE;
      UB           <= CTRL_INACTIVE;
      LB           <= CTRL_INACTIVE;
      Data_oe      <= 1'b0;
    end else begin
      if (load_c) begin
        A            <= bus.Addr[grant_c];
        Data_to_SRAM <= bus.WData[grant_c];
        lat_wr       <= bus.Wr[grant_c];
        lat_be       <= bus.BE[grant_c];
        lat_port     <= grant_c;
      end
      if (capture_c) begin
        bus.RData <= Data_from_SRAM;
      end
      bus.Ack <= ack_nx;
      CE      <= ce_nx;
      OE      <= oe_nx;
      WE      <= we_nx;
      UB      <= ub_nx;
      LB      <= lb_nx;
      Data_oe <= doe_nx;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: four instances covering round-robin, fixed priority and strobe widths 1/2/5.
module tb_sram_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance stimulus; instance 0: AC=2 RR, 1: AC=2 fixed, 2: AC=1 RR, 3: AC=5 RR.
  logic [1:0]            req_v   [4];
  logic [1:0]            wr_v    [4];
  logic [1:0][1:0]       be_v    [4];
  logic [1:0][19:0]      addr_v  [4];
  logic [1:0][15:0]      wdata_v [4];
  wire  [1:0]            ack_v   [4];
  wire  [15:0]           rdata_v [4];
  wire  [19:0]           a_v     [4];
  wire  [15:0]           dts_v   [4];
  wire                   doe_v   [4];
  wire                   ce_v    [4];
  wire                   oe_v    [4];
  wire                   we_v    [4];
  wire                   ub_v    [4];
  wire                   lb_v    [4];
  logic [15:0]           mem     [256];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned AC = (g == 2) ? 1 : (g == 3) ? 5 : 2;
    localparam int unsigned FR = (g == 1) ? 0 : 1;
    sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();
    assign bus.Req   = req_v[g];
    assign bus.Wr    = wr_v[g];
    assign bus.BE    = be_v[g];
    assign bus.Addr  = addr_v[g];
    assign bus.WData = wdata_v[g];
    assign ack_v[g]   = bus.Ack;
    assign rdata_v[g] = bus.RData;
    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC), .FAIR(FR)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .bus            (bus),
      .A              (a_v[g]),
      .Data_to_SRAM   (dts_v[g]),
      .Data_from_SRAM (mem[a_v[g][7:0]]),
      .Data_oe        (doe_v[g]),
      .CE             (ce_v[g]),
      .OE             (oe_v[g]),
      .WE             (we_v[g]),
      .UB             (ub_v[g]),
      .LB             (lb_v[g])
    );
  end

  // Byte-lane SRAM model written by instance 0 only.
  always @(posedge Clk) begin
    if (!ce_v[0] && !we_v[0]) begin
      if (!ub_v[0]) mem[a_v[0][7:0]][15:8] = dts_v[0][15:8];
      if (!lb_v[0]) mem[a_v[0][7:0]][7:0]  = dts_v[0][7:0];
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Runs one access on instance d and reports timing; hold=0 drops Req after the grant edge.
  task automatic run_access(input int d, input bit p, input bit wr, input logic [1:0] be,
                            input logic [19:0] addr, input logic [15:0] wd, input bit hold,
                            output int lat, output int strobe, output int nack,
                            output logic [15:0] rd, output bit ub_low, output bit lb_low);
    lat = -1; strobe = 0; nack = 0; rd = '0; ub_low = 1'b0; lb_low = 1'b0;
    wr_v[d][p] = wr; be_v[d][p] = be; addr_v[d][p] = addr; wdata_v[d][p] = wd;
    req_v[d][p] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!hold && k == 1) req_v[d][p] = 1'b0;
      if (wr ? !we_v[d] : !oe_v[d]) strobe++;
      if (!ub_v[d]) ub_low = 1'b1;
      if (!lb_v[d]) lb_low = 1'b1;
      if (ack_v[d][p]) begin
        nack++;
        if (lat < 0) begin
          lat = k;
          rd  = rdata_v[d];
        end
        req_v[d][p] = 1'b0;
      end
    end
  endtask

  // Both ports hold read requests until four Acks are seen.
  task automatic run_both(input int d, output logic [3:0] order, output logic [3:0][7:0] t,
                          output int n, output int dual);
    n = 0; dual = 0; order = '0; t = '0;
    wr_v[d] = 2'b00; be_v[d][0] = 2'b11; be_v[d][1] = 2'b11;
    addr_v[d][0] = 20'h00010; addr_v[d][1] = 20'h00020;
    req_v[d] = 2'b11;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      step();
      if (ack_v[d] == 2'b11) dual++;
      else if (ack_v[d] != 2'b00) begin
        order[n] = ack_v[d][1];
        t[n]     = 8'(k);
        n++;
      end
    end
    req_v[d] = 2'b00;
    step();
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if ({ce_v[d], oe_v[d], we_v[d], ub_v[d], lb_v[d]} !== 5'b11111) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: got %b want 11111", d, {ce_v[d], oe_v[d], we_v[d], ub_v[d], lb_v[d]});
      end
      n_checks++;
      if (a_v[d] !== 20'h0) begin n_fail++; $display("FAIL reset_addr dut%0d: got %h want 0", d, a_v[d]); end
      n_checks++;
      if (dts_v[d] !== 16'h0) begin n_fail++; $display("FAIL reset_wdata dut%0d: got %h want 0", d, dts_v[d]); end
      n_checks++;
      if (doe_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_doe dut%0d: got %b want 0", d, doe_v[d]); end
      n_checks++;
      if (ack_v[d] !== 2'b00) begin n_fail++; $display("FAIL reset_ack dut%0d: got %b want 00", d, ack_v[d]); end
      n_checks++;
      if (rdata_v[d] !== 16'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata_v[d]); end
    end
    Reset = 1'b0;
  endtask

  task automatic test_read();
    logic       exp_ce, exp_oe;
    logic [1:0] exp_ack;
    mem[8'h10] = 16'hBEEF;
    wr_v[0][0] = 1'b0; be_v[0][0] = 2'b11; addr_v[0][0] = 20'h00010; req_v[0][0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_ce  = (k <= 3) ? 1'b0 : 1'b1;
      exp_oe  = (k <= 2) ? 1'b0 : 1'b1;
      exp_ack = (k == 3) ? 2'b01 : 2'b00;
      n_checks++;
      if (ce_v[0] !== exp_ce) begin n_fail++; $display("FAIL read_ce k=%0d: got %b want %b", k, ce_v[0], exp_ce); end
      n_checks++;
      if (oe_v[0] !== exp_oe) begin n_fail++; $display("FAIL read_oe k=%0d: got %b want %b", k, oe_v[0], exp_oe); end
      n_checks++;
      if (we_v[0] !== 1'b1) begin n_fail++; $display("FAIL read_we k=%0d: got %b want 1", k, we_v[0]); end
      n_checks++;
      if (doe_v[0] !== 1'b0) begin n_fail++; $display("FAIL read_doe k=%0d: got %b want 0", k, doe_v[0]); end
      n_checks++;
      if (ack_v[0] !== exp_ack) begin n_fail++; $display("FAIL read_ack k=%0d: got %b want %b", k, ack_v[0], exp_ack); end
      if (k == 1) begin
        n_checks++;
        if (a_v[0] !== 20'h00010) begin n_fail++; $display("FAIL read_addr: got %h want 00010", a_v[0]); end
      end
      if (k == 3) begin
        n_checks++;
        if (rdata_v[0] !== 16'hBEEF) begin n_fail++; $display("FAIL read_rdata: got %h want beef", rdata_v[0]); end
        req_v[0][0] = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    logic       exp_we, exp_doe;
    logic [1:0] exp_ack;
    mem[8'h20] = 16'hAB00;
    wr_v[0][1] = 1'b1; be_v[0][1] = 2'b01; addr_v[0][1] = 20'h00020; wdata_v[0][1] = 16'h1234;
    req_v[0][1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_we  = (k <= 2) ? 1'b0 : 1'b1;
      exp_doe = (k <= 3) ? 1'b1 : 1'b0;
      exp_ack = (k == 3) ? 2'b10 : 2'b00;
      n_checks++;
      if (we_v[0] !== exp_we) begin n_fail++; $display("FAIL write_we k=%0d: got %b want %b", k, we_v[0], exp_we); end
      n_checks++;
      if (oe_v[0] !== 1'b1) begin n_fail++; $display("FAIL write_oe k=%0d: got %b want 1", k, oe_v[0]); end
      n_checks++;
      if (doe_v[0] !== exp_doe) begin n_fail++; $display("FAIL write_doe k=%0d: got %b want %b", k, doe_v[0], exp_doe); end
      n_checks++;
      if (ack_v[0] !== exp_ack) begin n_fail++; $display("FAIL write_ack k=%0d: got %b want %b", k, ack_v[0], exp_ack); end
      if (k <= 2) begin
        n_checks++;
        if ({ub_v[0], lb_v[0]} !== 2'b10) begin n_fail++; $display("FAIL write_lanes k=%0d: got %b want 10", k, {ub_v[0], lb_v[0]}); end
        n_checks++;
        if (dts_v[0] !== 16'h1234) begin n_fail++; $display("FAIL write_data k=%0d: got %h want 1234", k, dts_v[0]); end
      end
      if (k == 3) req_v[0][1] = 1'b0;
    end
    n_checks++;
    if (mem[8'h20] !== 16'hAB34) begin n_fail++; $display("FAIL write_mem: got %h want ab34", mem[8'h20]); end
  endtask

  task automatic test_arb_fair();
    logic [3:0]      order;
    logic [3:0][7:0] t;
    int              n, dual;
    run_both(0, order, t, n, dual);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL fair_count: got %0d want 4", n); end
    n_checks++;
    if (dual !== 0) begin n_fail++; $display("FAIL fair_dual_ack: got %0d want 0", dual); end
    n_checks++;
    if (order !== 4'b1010) begin n_fail++; $display("FAIL fair_order: got %b want 1010", order); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (t[i] !== 8'(3 + 4 * i)) begin n_fail++; $display("FAIL fair_cycle%0d: got %0d want %0d", i, t[i], 3 + 4 * i); end
    end
  endtask

  task automatic test_arb_fixed();
    logic [3:0]      order;
    logic [3:0][7:0] t;
    int              n, dual;
    run_both(1, order, t, n, dual);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL fixed_count: got %0d want 4", n); end
    n_checks++;
    if (order !== 4'b0000) begin n_fail++; $display("FAIL fixed_order: got %b want 0000", order); end
    n_checks++;
    if (t[3] !== 8'd15) begin n_fail++; $display("FAIL fixed_cycle3: got %0d want 15", t[3]); end
  endtask

  task automatic test_reset_mid_write();
    int          lat, str, na;
    logic [15:0] rd;
    bit          ul, ll;
    logic [1:0]  first;
    // A completed port-0 access leaves port 1 preferred; reset must restore port 0.
    run_access(0, 1'b0, 1'b0, 2'b11, 20'h00010, 16'h0, 1'b1, lat, str, na, rd, ul, ll);
    wr_v[0][1] = 1'b1; be_v[0][1] = 2'b11; addr_v[0][1] = 20'h00030; wdata_v[0][1] = 16'hDEAD;
    req_v[0][1] = 1'b1;
    step();
    n_checks++;
    if (we_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_started: got we=%b want 0", we_v[0]); end
    Reset = 1'b1;
    req_v[0][1] = 1'b0;
    step();
    n_checks++;
    if ({ce_v[0], oe_v[0], we_v[0], ub_v[0], lb_v[0]} !== 5'b11111) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b want 11111", {ce_v[0], oe_v[0], we_v[0], ub_v[0], lb_v[0]});
    end
    n_checks++;
    if (doe_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_doe: got %b want 0", doe_v[0]); end
    n_checks++;
    if (ack_v[0] !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 00", ack_v[0]); end
    Reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if ({ack_v[0], ce_v[0]} !== 3'b001) begin n_fail++; $display("FAIL rst_mid_idle k=%0d: got ack=%b ce=%b want 00/1", k, ack_v[0], ce_v[0]); end
    end
    wr_v[0] = 2'b00; addr_v[0][0] = 20'h00010; addr_v[0][1] = 20'h00020; req_v[0] = 2'b11;
    first = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ack_v[0] != 2'b00 && first == 2'b00) begin
        first    = ack_v[0];
        req_v[0] = 2'b00;
      end
    end
    n_checks++;
    if (first !== 2'b01) begin n_fail++; $display("FAIL rst_mid_first_grant: got %b want 01", first); end
  endtask

  task automatic test_early_drop();
    int          lat, str, na;
    logic [15:0] rd;
    bit          ul, ll;
    run_access(0, 1'b0, 1'b0, 2'b11, 20'h00010, 16'h0, 1'b0, lat, str, na, rd, ul, ll);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL drop_latency: got %0d want 3", lat); end
    n_checks++;
    if (na !== 1) begin n_fail++; $display("FAIL drop_ack_count: got %0d want 1", na); end
    n_checks++;
    if (str !== 2) begin n_fail++; $display("FAIL drop_strobe: got %0d want 2", str); end
  endtask

  task automatic test_be_zero();
    int          lat, str, na;
    logic [15:0] rd;
    bit          ul, ll;
    run_access(0, 1'b0, 1'b0, 2'b00, 20'h00010, 16'h0, 1'b1, lat, str, na, rd, ul, ll);
    n_checks++;
    if ({ul, ll} !== 2'b00) begin n_fail++; $display("FAIL be0_lanes: got ub_low,lb_low=%b want 00", {ul, ll}); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL be0_latency: got %0d want 3", lat); end
    n_checks++;
    if (str !== 2) begin n_fail++; $display("FAIL be0_strobe: got %0d want 2", str); end
    n_checks++;
    if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL be0_rdata: got %h want beef", rd); end
  endtask

  task automatic test_sweep();
    int          lat, str, na;
    logic [15:0] rd;
    bit          ul, ll;
    mem[8'h40] = 16'h5A5A;
    run_access(2, 1'b0, 1'b0, 2'b11, 20'h00040, 16'h0, 1'b1, lat, str, na, rd, ul, ll);
    n_checks++;
    if (str !== 1) begin n_fail++; $display("FAIL sweep1_strobe: got %0d want 1", str); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL sweep1_latency: got %0d want 2", lat); end
    n_checks++;
    if (rd !== 16'h5A5A) begin n_fail++; $display("FAIL sweep1_rdata: got %h want 5a5a", rd); end
    run_access(3, 1'b0, 1'b0, 2'b11, 20'h00040, 16'h0, 1'b1, lat, str, na, rd, ul, ll);
    n_checks++;
    if (str !== 5) begin n_fail++; $display("FAIL sweep5_strobe: got %0d want 5", str); end
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL sweep5_latency: got %0d want 6", lat); end
    n_checks++;
    if (rd !== 16'h5A5A) begin n_fail++; $display("FAIL sweep5_rdata: got %h want 5a5a", rd); end
    run_access(3, 1'b1, 1'b1, 2'b11, 20'h00050, 16'h7777, 1'b1, lat, str, na, rd, ul, ll);
    n_checks++;
    if (str !== 5) begin n_fail++; $display("FAIL sweep5w_strobe: got %0d want 5", str); end
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL sweep5w_latency: got %0d want 6", lat); end
    n_checks++;
    if (na !== 1) begin n_fail++; $display("FAIL sweep5w_ack_count: got %0d want 1", na); end
    run_access(0, 1'b0, 1'b0, 2'b11, 20'h00040, 16'h0, 1'b1, lat, str, na, rd, ul, ll);
    n_checks++;
    if (str !== 2) begin n_fail++; $display("FAIL sweep2_strobe: got %0d want 2", str); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL sweep2_latency: got %0d want 3", lat); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    for (int d = 0; d < 4; d++) begin
      req_v[d] = '0; wr_v[d] = '0; be_v[d] = '0; addr_v[d] = '0; wdata_v[d] = '0;
    end
    test_reset();
    test_read();
    test_write();
    test_arb_fair();
    test_arb_fixed();
    test_reset_mid_write();
    test_early_drop();
    test_be_zero();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences all accesses to the external 16-bit asynchronous SRAM (A[19:0], CE/OE/WE/UB/LB active-low, shared data bus).
- Shares the SRAM between two requesters: port 0 is the processor, port 1 is a loader/debug master (switch loader, display readback).
- Generates multi-cycle SRAM timing from a single clock and arbitrates between simultaneous requests.
- Sits at the top level between the CPU/loader and the pins. The top level owns the bus tristate, using Data_oe.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, cycles the strobe is held low. Legal range is 1 or more; 0 fails elaboration.
- FAIR, 1, arbitration mode. 1 = round-robin, 0 = fixed priority with port 0 winning.

Ports:
- Clk  in  1  system clock. This is the block's only clock.
- Reset  in  1  synchronous, active-high reset.
- Req  in  2  per-port request. Bit n belongs to port n.
- Wr  in  2  per-port write flag. 1 = write, 0 = read.
- BE  in  2x2  per-port byte enables. [1] = upper byte, [0] = lower byte.
- Addr  in  2xADDR_W  per-port address.
- WData  in  2xDATA_W  per-port write data.
- RData  out  DATA_W  read data, shared by both ports. Valid while Ack is high.
- Ack  out  2  per-port single-cycle completion pulse.
- A  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  DATA_W  write data for the pins.
- Data_from_SRAM  in  DATA_W  pin data as seen by the top-level tristate.
- Data_oe  out  1  enables the top-level tristate driver.
- CE, OE, WE, UB, LB  out  1 each  SRAM controls, all active-low.

Behaviour:
- Reset state: IDLE. CE=OE=WE=UB=LB=1, A=0, Data_to_SRAM=0, Data_oe=0, Ack=00, RData=0. Round-robin pointer set to "port 0 preferred".
- Reset has priority over everything. Asserting Reset mid-access aborts the access: all controls go high on the next edge and no Ack is issued.
- IDLE state, with any Req bit high:
  - Select a winner.
  - FAIR=1: if only one port requests, it wins; if both request, the port not granted last wins.
  - FAIR=0: port 0 always wins over port 1.
  - On the same edge, latch the winner's Addr, Wr, BE and WData, and drive A from the latched values.
  - Transition to ACCESS with counter = ACCESS_CYCLES-1.
- ACCESS state:
  - Controls: CE=0; UB=~BE[1]; LB=~BE[0].
  - Read: OE=0, WE=1, Data_oe=0.
  - Write: OE=1, WE=0, Data_oe=1, Data_to_SRAM = latched data.
  - Counter decrements each cycle.
  - When the counter reaches 0: for a read, capture Data_from_SRAM into RData; then go to RECOVER.
- RECOVER state (1 cycle):
  - WE=1 and OE=1.
  - CE stays 0 and A holds. For a write, Data_oe stays 1, giving data hold past WE rising.
  - Ack[winner]=1 for exactly this cycle. RData stays valid this cycle.
  - Update the round-robin pointer, then go to IDLE, where all controls go high.
- Latency: Req seen high in IDLE at cycle 0 gives Ack at cycle ACCESS_CYCLES+1. One access takes ACCESS_CYCLES+2 cycles.
- Requester contract:
  - Hold Req, Wr, BE, Addr and WData stable until Ack.
  - Dropping Req before Ack is allowed. The already-latched access still completes and still Acks.
  - Req still high in the cycle after Ack counts as a new request.
- Back-to-back: if both ports hold Req under FAIR=1, grants alternate 0,1,0,1. Under FAIR=0, port 1 starves while port 0 holds Req; this is intended.
- Reads with BE=00 still perform the cycle with UB=LB=1. RData is then undefined-but-stable (the captured bus value) and Ack is issued.
- A and the latched fields never change outside IDLE.
- Ack is never high for both ports at once.
- Ack is never issued without a matching grant.

Decomposition:
- Package sram_pkg holds:
  - typedef enum of states {IDLE, ACCESS, RECOVER};
  - typedef for port index (1 bit);
  - constants NUM_PORTS=2 and CTRL_INACTIVE=1'b1.
- Sub-module rr_arbiter2 provides the combinational grant from Req, the pointer and FAIR. It also registers the pointer update on a done strobe.
- The FSM, latches and SRAM drive logic stay in sram_arbiter.

Test Plan:
- Read, ACCESS_CYCLES=2: port 0 reads Addr=0x00010 with SRAM model holding 0xBEEF. Required: CE=0 and OE=0 for 2 cycles, WE=1, Ack[0] at cycle 3, RData=0xBEEF, Data_oe=0 throughout.
- Write: port 1 writes 0x1234 to 0x00020 with BE=01. Required: WE=0 for 2 cycles, LB=0, UB=1, Data_oe=1 through RECOVER, Ack[1] at cycle 3, model upper byte unchanged.
- Arbitration, FAIR=1: both ports hold Req for 4 accesses. Required: Ack order 0,1,0,1, each 4 cycles apart. With FAIR=0, the order is 0,0,0,0.
- Reset mid-write: Reset asserted in the 1st ACCESS cycle. Required: next edge gives all controls=1, Data_oe=0, Ack=00, state IDLE. A later request from port 0 is served first.
- Early Req drop: port 0 raises Req for 1 cycle only. Required: the access completes, with Ack[0] at cycle ACCESS_CYCLES+1 and no second access.
- Parameter sweep: ACCESS_CYCLES=1 and 5. Required: strobe width equals ACCESS_CYCLES and Ack latency equals ACCESS_CYCLES+1 in every case.
